// File: rtl/inst_cache.sv
// Direct-mapped, one-word-per-line instruction cache for the IF stage.
// A sweep FSM clears the valid bits one line per cycle after reset or a flush.
module inst_cache #(
  parameter int ADDR_W  = 32,
  parameter int INST_W  = 32,
  parameter int INDEX_W = 7,
  parameter int MEM_HI  = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [INST_W-1:0] winst_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic              hit_o,
  output logic [INST_W-1:0] inst_o,
  output logic              busy_o
);

  localparam int LINES = 2 ** INDEX_W;
  localparam int TAG_W = MEM_HI - INDEX_W - 1;

  typedef enum logic {
    ST_SWEEP,
    ST_READY
  } state_e;

  state_e             state_q, state_d;
  logic [INDEX_W-1:0] ptr_q, ptr_d;
  logic [LINES-1:0]   valid_q, valid_d;

  logic [TAG_W-1:0]   tag_mem  [LINES];
  logic [INST_W-1:0]  data_mem [LINES];

  logic [INDEX_W-1:0] ridx, widx;
  logic [TAG_W-1:0]   rtag, wtag;
  logic               ready, fill_en, stored_hit, bypass;
  logic               unused_addr_bits;

  assign ridx = raddr_i[INDEX_W+1:2];
  assign rtag = raddr_i[MEM_HI:INDEX_W+2];
  assign widx = waddr_i[INDEX_W+1:2];
  assign wtag = waddr_i[MEM_HI:INDEX_W+2];

  // Byte offset and bits beyond the 18-bit memory space play no part in lookup.
  assign unused_addr_bits = ^{raddr_i[ADDR_W-1:MEM_HI+1], raddr_i[1:0],
                              waddr_i[ADDR_W-1:MEM_HI+1], waddr_i[1:0]};

  assign ready   = (state_q == ST_READY);
  assign fill_en = ready && we_i && !flush_i;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    valid_d = valid_q;
    if (state_q == ST_SWEEP) begin
      valid_d[ptr_q] = 1'b0;
      ptr_d          = ptr_q + 1'b1;
      if (ptr_q == {INDEX_W{1'b1}}) begin
        state_d = ST_READY;
      end
    end else if (fill_en) begin
      valid_d[widx] = 1'b1;
    end
    // A flush always restarts the sweep from line 0, dropping any same-cycle fill.
    if (flush_i) begin
      state_d = ST_SWEEP;
      ptr_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_SWEEP;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Valid bits need no reset of their own: the sweep clears every line before READY.
  always_ff @(posedge clk) begin
    valid_q <= valid_d;
  end

  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_mem[widx]  <= wtag;
      data_mem[widx] <= winst_i;
    end
  end

  assign stored_hit = valid_q[ridx] && (tag_mem[ridx] == rtag);
  assign bypass     = ready && we_i && (widx == ridx) && (wtag == rtag);

  always_comb begin
    hit_o  = 1'b0;
    inst_o = '0;
    if (bypass) begin
      hit_o  = 1'b1;
      inst_o = winst_i;
    end else if (ready && stored_hit) begin
      hit_o  = 1'b1;
      inst_o = data_mem[ridx];
    end
  end

  assign busy_o = (state_q == ST_SWEEP);

endmodule

// File: tb/tb_inst_cache.sv
// Directed bench for inst_cache: sweep timing, fill/lookup, aliasing, bypass,
// flush and reset during a sweep.
module tb_inst_cache;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush_i = 1'b0;
  logic        we_i = 1'b0;
  logic [31:0] waddr_i = '0;
  logic [31:0] winst_i = '0;
  logic [31:0] raddr_i = '0;
  logic        hit_o;
  logic [31:0] inst_o;
  logic        busy_o;

  int checks = 0;
  int failures = 0;

  inst_cache #(
    .ADDR_W(32), .INST_W(32), .INDEX_W(7), .MEM_HI(17)
  ) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i), .we_i(we_i),
    .waddr_i(waddr_i), .winst_i(winst_i), .raddr_i(raddr_i),
    .hit_o(hit_o), .inst_o(inst_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_fill(input logic [31:0] a, input logic [31:0] d);
    we_i = 1'b1; waddr_i = a; winst_i = d;
    step();
    we_i = 1'b0;
  endtask

  // Counts busy cycles while probing a lookup address; optionally attempts a
  // fill late in the sweep (after its line has already been cleared).
  task automatic run_sweep(input logic [31:0] probe, input bit try_fill,
                           output int n, output bit hit_seen);
    n = 0; hit_seen = 1'b0; raddr_i = probe;
    #1;
    while (busy_o === 1'b1 && n < 400) begin
      if (hit_o !== 1'b0 || inst_o !== 32'h0) hit_seen = 1'b1;
      if (try_fill && n == 120) begin
        we_i = 1'b1; waddr_i = 32'h0000_0500; winst_i = 32'h1234_5678;
      end
      step();
      we_i = 1'b0;
      n++;
      #1;
    end
  endtask

  task automatic test_reset();
    int n; bit hs;
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    checks++;
    if (busy_o !== 1'b1) begin
      failures++; $display("FAIL reset_busy: got %b want 1", busy_o);
    end
    run_sweep(32'h0000_0010, 1'b0, n, hs);
    checks++;
    if (n !== 128) begin
      failures++; $display("FAIL reset_sweep_len: got %0d want 128", n);
    end
    checks++;
    if (hs !== 1'b0) begin
      failures++; $display("FAIL reset_hit_during_sweep: got %b want 0", hs);
    end
    checks++;
    if (busy_o !== 1'b0) begin
      failures++; $display("FAIL reset_busy_after: got %b want 0", busy_o);
    end
  endtask

  task automatic test_fill();
    raddr_i = 32'h0000_0014;
    #1;
    checks++;
    if (hit_o !== 1'b0 || inst_o !== 32'h0) begin
      failures++; $display("FAIL cold_miss: hit=%b inst=%h want 0/0", hit_o, inst_o);
    end
    do_fill(32'h0000_0010, 32'h0050_0093);
    raddr_i = 32'h0000_0010;
    #1;
    checks++;
    if (hit_o !== 1'b1 || inst_o !== 32'h0050_0093) begin
      failures++; $display("FAIL fill_hit: hit=%b inst=%h want 1/00500093", hit_o, inst_o);
    end
  endtask

  task automatic test_alias();
    do_fill(32'h0000_0010, 32'h1111_1111);
    do_fill(32'h0000_0210, 32'h2222_2222);
    raddr_i = 32'h0000_0010;
    #1;
    checks++;
    if (hit_o !== 1'b0 || inst_o !== 32'h0) begin
      failures++; $display("FAIL alias_old_miss: hit=%b inst=%h want 0/0", hit_o, inst_o);
    end
    raddr_i = 32'h0000_0210;
    #1;
    checks++;
    if (hit_o !== 1'b1 || inst_o !== 32'h2222_2222) begin
      failures++; $display("FAIL alias_new_hit: hit=%b inst=%h want 1/22222222", hit_o, inst_o);
    end
    raddr_i = 32'hFFFC_0213;
    #1;
    checks++;
    if (hit_o !== 1'b1 || inst_o !== 32'h2222_2222) begin
      failures++; $display("FAIL ignored_bits_hit: hit=%b inst=%h want 1/22222222", hit_o, inst_o);
    end
  endtask

  task automatic test_bypass();
    we_i = 1'b1; waddr_i = 32'h0000_0040; winst_i = 32'hDEAD_BEEF;
    raddr_i = 32'h0000_0040;
    #1;
    checks++;
    if (hit_o !== 1'b1 || inst_o !== 32'hDEAD_BEEF) begin
      failures++; $display("FAIL bypass_cold: hit=%b inst=%h want 1/deadbeef", hit_o, inst_o);
    end
    step();
    we_i = 1'b0;
    #1;
    checks++;
    if (hit_o !== 1'b1 || inst_o !== 32'hDEAD_BEEF) begin
      failures++; $display("FAIL bypass_stored: hit=%b inst=%h want 1/deadbeef", hit_o, inst_o);
    end
    we_i = 1'b1; winst_i = 32'hCAFE_F00D;
    #1;
    checks++;
    if (hit_o !== 1'b1 || inst_o !== 32'hCAFE_F00D) begin
      failures++; $display("FAIL bypass_override: hit=%b inst=%h want 1/cafef00d", hit_o, inst_o);
    end
    step();
    we_i = 1'b0;
  endtask

  task automatic test_flush();
    int n; bit hs;
    logic [31:0] addrs [4];
    addrs[0] = 32'h0000_0100; addrs[1] = 32'h0000_0104;
    addrs[2] = 32'h0000_0108; addrs[3] = 32'h0000_01FC;
    for (int i = 0; i < 4; i++) do_fill(addrs[i], 32'hA000_0000 + i);
    raddr_i = addrs[3];
    #1;
    checks++;
    if (hit_o !== 1'b1 || inst_o !== 32'hA000_0003) begin
      failures++; $display("FAIL flush_prefill_hit: hit=%b inst=%h want 1/a0000003", hit_o, inst_o);
    end
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    run_sweep(addrs[3], 1'b0, n, hs);
    checks++;
    if (n !== 128) begin
      failures++; $display("FAIL flush_sweep_len: got %0d want 128", n);
    end
    checks++;
    if (hs !== 1'b0) begin
      failures++; $display("FAIL flush_hit_during_sweep: got %b want 0", hs);
    end
    for (int i = 0; i < 4; i++) begin
      raddr_i = addrs[i];
      #1;
      checks++;
      if (hit_o !== 1'b0 || inst_o !== 32'h0) begin
        failures++;
        $display("FAIL flush_line%0d_miss: hit=%b inst=%h want 0/0", i, hit_o, inst_o);
      end
    end
  endtask

  task automatic test_rst_mid_sweep();
    int n; bit hs;
    do_fill(32'h0000_0010, 32'h0050_0093);
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 50; i++) step();
    checks++;
    if (busy_o !== 1'b1) begin
      failures++; $display("FAIL mid_sweep_busy: got %b want 1", busy_o);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    run_sweep(32'h0000_0500, 1'b1, n, hs);
    checks++;
    if (n !== 128) begin
      failures++; $display("FAIL restart_sweep_len: got %0d want 128", n);
    end
    checks++;
    if (hs !== 1'b0) begin
      failures++; $display("FAIL restart_hit_during_sweep: got %b want 0", hs);
    end
    raddr_i = 32'h0000_0500;
    #1;
    checks++;
    if (hit_o !== 1'b0 || inst_o !== 32'h0) begin
      failures++; $display("FAIL busy_fill_dropped: hit=%b inst=%h want 0/0", hit_o, inst_o);
    end
    raddr_i = 32'h0000_0010;
    #1;
    checks++;
    if (hit_o !== 1'b0) begin
      failures++; $display("FAIL restart_cleared: hit=%b want 0", hit_o);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_alias();
    test_bypass();
    test_flush();
    test_rst_mid_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
